// File: rtl/slot_game_controller.sv
// Slot machine round sequencer: detects the spin edge, validates the bet against the balance,
// spins three reels from a free-running LFSR, stops them in order, then strobes payout once.
module slot_game_controller #(
  parameter int SPIN_CYCLES = 25_000_000,
  parameter int STOP_GAP    = 12_500_000,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spin,
  input  logic [6:0] bet,
  input  logic [9:0] balance,
  output logic [2:0] first,
  output logic [2:0] second,
  output logic [2:0] third,
  output logic [6:0] bet_out,
  output logic       payout,
  output logic       busy,
  output logic       reject,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPIN3  = 3'd1,
    ST_SPIN2  = 3'd2,
    ST_SPIN1  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_PAY    = 3'd5,
    ST_SHOW   = 3'd6
  } state_t;

  localparam logic [26:0] LP_SPIN = 27'(SPIN_CYCLES);
  localparam logic [26:0] LP_GAP  = 27'(STOP_GAP);
  localparam logic [26:0] LP_SHOW = 27'(SHOW_CYCLES);
  localparam logic [15:0] LP_SEED = 16'hACE1;

  state_t      r_state;
  logic [26:0] r_cnt;
  logic [15:0] r_lfsr;
  logic        r_spin_d;
  logic [2:0]  r_first;
  logic [2:0]  r_second;
  logic [2:0]  r_third;
  logic [6:0]  r_bet_out;
  logic        r_payout;
  logic        r_busy;
  logic        r_reject;

  logic [6:0]  w_bet_eff;
  logic        w_request;
  logic        w_accept;
  logic        w_cnt_done;
  logic        w_lfsr_fb;

  assign w_bet_eff  = (bet > 7'd100) ? 7'd100 : bet;
  assign w_request  = spin & ~r_spin_d;
  assign w_accept   = (w_bet_eff != 7'd0) && ({3'b000, w_bet_eff} <= balance);
  // Counter is loaded with N and expires on the cycle it reads 1, giving exactly N cycles per phase.
  assign w_cnt_done = (r_cnt == 27'd1);
  // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 map to bits 15,13,12,10.
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lfsr   <= LP_SEED;
      r_spin_d <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
      r_spin_d <= spin;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_first   <= '0;
      r_second  <= '0;
      r_third   <= '0;
      r_bet_out <= '0;
      r_payout  <= 1'b0;
      r_busy    <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_payout <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_request) begin
            if (w_accept) begin
              r_bet_out <= w_bet_eff;
              r_cnt     <= LP_SPIN;
              r_state   <= ST_SPIN3;
              r_busy    <= 1'b1;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        ST_SPIN3: begin
          r_first  <= r_lfsr[2:0];
          r_second <= r_lfsr[7:5];
          r_third  <= r_lfsr[12:10];
          if (w_cnt_done) begin
            r_cnt   <= LP_GAP;
            r_state <= ST_SPIN2;
          end else begin
            r_cnt <= r_cnt - 27'd1;
          end
        end
        ST_SPIN2: begin
          r_second <= r_lfsr[7:5];
          r_third  <= r_lfsr[12:10];
          if (w_cnt_done) begin
            r_cnt   <= LP_GAP;
            r_state <= ST_SPIN1;
          end else begin
            r_cnt <= r_cnt - 27'd1;
          end
        end
        ST_SPIN1: begin
          r_third <= r_lfsr[12:10];
          if (w_cnt_done) begin
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - 27'd1;
          end
        end
        ST_SETTLE: begin
          r_payout <= 1'b1;
          r_state  <= ST_PAY;
        end
        ST_PAY: begin
          r_cnt   <= LP_SHOW;
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (w_cnt_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 27'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign first   = r_first;
  assign second  = r_second;
  assign third   = r_third;
  assign bet_out = r_bet_out;
  assign payout  = r_payout;
  assign busy    = r_busy;
  assign reject  = r_reject;
  assign state   = r_state;

endmodule

// File: tb/tb_slot_game_controller.sv
// Bench for slot_game_controller: directed and randomized rounds checked against a timeline
// model that derives reel values from a reference LFSR history.
module tb_slot_game_controller;

  localparam int S     = 4;
  localparam int G     = 2;
  localparam int H     = 3;
  localparam int ROUND = S + 2 * G + 2 + H;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       spin = 1'b0;
  logic [6:0] bet = '0;
  logic [9:0] balance = '0;
  logic [2:0] first, second, third;
  logic [6:0] bet_out;
  logic       payout, busy, reject;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr = 16'h0000;
  logic [15:0] hist[$];
  logic [6:0]  exp_q[$];
  logic [2:0]  e_first = '0, e_second = '0, e_third = '0;
  logic [6:0]  e_bet = '0;

  slot_game_controller #(
    .SPIN_CYCLES(S),
    .STOP_GAP   (G),
    .SHOW_CYCLES(H)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .spin   (spin),
    .bet    (bet),
    .balance(balance),
    .first  (first),
    .second (second),
    .third  (third),
    .bet_out(bet_out),
    .payout (payout),
    .busy   (busy),
    .reject (reject),
    .state  (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Reference LFSR: feedback is the parity of the tap mask for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  // State expected after the k-th edge following the accepting edge (k = 0 is the accept edge).
  function automatic int exp_state(input int k);
    if (k < S)               return 1;
    if (k < S + G)           return 2;
    if (k < S + 2 * G)       return 3;
    if (k == S + 2 * G)      return 4;
    if (k == S + 2 * G + 1)  return 5;
    if (k < ROUND)           return 6;
    return 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!resetn) m_lfsr = 16'hACE1;
    else         m_lfsr = lfsr_next(m_lfsr);
    hist.push_back(m_lfsr);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"},  32'(state),   32'd0);
    chk({tag, "_busy"},   32'(busy),    32'd0);
    chk({tag, "_payout"}, 32'(payout),  32'd0);
    chk({tag, "_first"},  32'(first),   32'(e_first));
    chk({tag, "_second"}, 32'(second),  32'(e_second));
    chk({tag, "_third"},  32'(third),   32'(e_third));
    chk({tag, "_bet"},    32'(bet_out), 32'(e_bet));
  endtask

  // driver: produce a fresh rising edge on spin; returns after the request edge E0
  task automatic spin_request(input logic [6:0] b, input logic [9:0] bal, input bit hold,
                              output bit acc);
    logic [6:0] eff;
    bet     = b;
    balance = bal;
    spin    = 1'b0;
    tick();
    spin = 1'b1;
    tick();
    if (!hold) spin = 1'b0;
    eff = (b > 7'd100) ? 7'd100 : b;
    acc = (eff != 7'd0) && ({3'b000, eff} <= bal);
    chk("req_reject", 32'(reject), acc ? 32'd0 : 32'd1);
    if (acc) begin
      exp_q.push_back(eff);
      chk("acc_state",   32'(state),   32'd1);
      chk("acc_busy",    32'(busy),    32'd1);
      chk("acc_bet_out", 32'(bet_out), 32'(eff));
    end else begin
      chk_idle("rej");
      tick();
      chk("rej_pulse_end", 32'(reject), 32'd0);
      chk_idle("rej_after");
    end
  endtask

  // Follow an accepted round edge by edge up to edge stop_k; bet/balance are scrambled mid-round.
  task automatic play_round(input logic [6:0] mid_bet, input int stop_k);
    int i0;
    logic [15:0] v1, v2, v3;
    logic [6:0] locked;
    i0 = hist.size() - 1;
    locked = exp_q[0];
    for (int k = 1; k <= stop_k; k++) begin
      if (k == 2) begin
        bet     = mid_bet;
        balance = 10'($urandom_range(0, 1023));
      end
      tick();
      v1 = hist[i0 + imin(k, S) - 1];
      v2 = hist[i0 + imin(k, S + G) - 1];
      v3 = hist[i0 + imin(k, S + 2 * G) - 1];
      chk("rnd_state",  32'(state),  32'(exp_state(k)));
      chk("rnd_busy",   32'(busy),   (exp_state(k) != 0) ? 32'd1 : 32'd0);
      chk("rnd_payout", 32'(payout), (k == S + 2 * G + 1) ? 32'd1 : 32'd0);
      chk("rnd_reject", 32'(reject), 32'd0);
      chk("rnd_first",  32'(first),  32'(v1[2:0]));
      chk("rnd_second", 32'(second), 32'(v2[7:5]));
      chk("rnd_third",  32'(third),  32'(v3[12:10]));
      if (k == S + 2 * G + 1) chk("payout_bet", 32'(bet_out), 32'(exp_q.pop_front()));
      else                    chk("rnd_bet",    32'(bet_out), 32'(locked));
      if (k == ROUND) begin
        e_first  = v1[2:0];
        e_second = v2[7:5];
        e_third  = v3[12:10];
        e_bet    = locked;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    exp_q.delete();
    e_first = '0; e_second = '0; e_third = '0; e_bet = '0;
    chk("rst_reject", 32'(reject), 32'd0);
    chk_idle("rst");
    resetn = 1'b1;
  endtask

  initial begin
    bit acc;
    logic [6:0] rb;
    logic [9:0] rbal;

    do_reset();
    tick();
    chk_idle("post_rst");

    // normal round, bet 10 against balance 100
    spin_request(7'd10, 10'd100, 1'b0, acc);
    play_round(7'd10, ROUND);

    // rejects and exact-balance boundary
    spin_request(7'd0, 10'd100, 1'b0, acc);
    spin_request(7'd6, 10'd5, 1'b0, acc);
    spin_request(7'd1, 10'd0, 1'b0, acc);
    spin_request(7'd6, 10'd6, 1'b0, acc);
    play_round(7'd99, ROUND);

    // clamp, and bet change mid-spin
    spin_request(7'd120, 10'd500, 1'b0, acc);
    play_round(7'd3, ROUND);
    spin_request(7'd127, 10'd100, 1'b0, acc);
    play_round(7'd0, ROUND);

    // held button: one round only, then a fresh edge starts another
    spin_request(7'd20, 10'd300, 1'b1, acc);
    play_round(7'd20, ROUND);
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("held_reject", 32'(reject), 32'd0);
      chk_idle("held");
    end
    spin = 1'b0;
    spin_request(7'd21, 10'd300, 1'b0, acc);
    play_round(7'd21, ROUND);

    // reset while in SPIN2 aborts without payout
    spin_request(7'd15, 10'd200, 1'b0, acc);
    play_round(7'd15, S + 1);
    chk("abort_in_spin2", 32'(state), 32'd2);
    do_reset();
    for (int i = 0; i < 2 * ROUND; i++) begin
      tick();
      chk("abort_reject", 32'(reject), 32'd0);
      chk_idle("abort");
    end

    // deterministic sequence from reset: spin request lands on cycle 2
    do_reset();
    spin_request(7'd50, 10'd50, 1'b0, acc);
    play_round(7'd50, ROUND);

    // randomized requests against the reference model
    for (int n = 0; n < 12; n++) begin
      rb   = 7'($urandom_range(0, 127));
      rbal = 10'($urandom_range(0, 160));
      spin_request(rb, rbal, 1'b0, acc);
      if (acc) play_round(7'($urandom_range(0, 127)), ROUND);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slot_game_controller.md
# slot_game_controller

Round sequencer for the slot machine. It edge-detects the player's spin button and validates the bet against the current balance. It then animates the three reels from a free-running LFSR, stops them one at a time, and issues a single-cycle `payout` strobe to the betting datapath. It sits between the board inputs (button, bet switches) and the betting datapath. It drives that datapath's `first`/`second`/`third`/`bet`/`payout` inputs and reads back its binary balance.

## Interface
Parameters:
- `SPIN_CYCLES`, default 25_000_000: cycles all three reels spin before reel 1 stops; must be ≥1
- `STOP_GAP`, default 12_500_000: cycles between successive reel stops; must be ≥1
- `SHOW_CYCLES`, default 50_000_000: result hold time after payout before a new spin is accepted; must be ≥1

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge
- `resetn`  in  1  synchronous, active-low reset
- `spin`  in  1  spin button (level, already synchronised); a round is requested by its rising edge only
- `bet`  in  7  requested bet; values >100 are treated as 100
- `balance`  in  10  current binary balance from the betting datapath
- `first`, `second`, `third`  out  3 each  reel symbols to the datapath and display
- `bet_out`  out  7  bet locked for the current round, feeds the datapath `bet`
- `payout`  out  1  one-cycle strobe commanding the balance update
- `busy`  out  1  high in every state except IDLE
- `reject`  out  1  one-cycle pulse when a spin request is refused
- `state`  out  3  current FSM state encoding, for debug LEDs

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. It loads 16'hACE1 on reset and advances every cycle in all states. Reel sources are `lfsr[2:0]`, `lfsr[7:5]` and `lfsr[12:10]`.
- **Effective bet:** `bet_eff = (bet > 100) ? 100 : bet`.
- **Edge detect:** `spin_d` is registered every cycle in all states. A request is `spin & ~spin_d`.
- **FSM states:** IDLE=0, SPIN3=1, SPIN2=2, SPIN1=3, SETTLE=4, PAY=5, SHOW=6. A 27-bit down-counter times SPIN3, SPIN2, SPIN1 and SHOW.
- **IDLE, on a request:**
  - Accepted if `bet_eff != 0 && bet_eff <= balance`: latch `bet_out <= bet_eff`, load the counter with SPIN_CYCLES, go to SPIN3.
  - Otherwise: pulse `reject` for one cycle, stay in IDLE, leave the reels and `bet_out` unchanged.
- **SPIN3:** all three reels load their LFSR slices every cycle. When the counter expires, `first` holds its last loaded value, the counter loads STOP_GAP, and the FSM goes to SPIN2.
- **SPIN2:** `second` and `third` keep updating; `first` is frozen. On expiry `second` freezes and the FSM goes to SPIN1 with the counter reloaded.
- **SPIN1:** only `third` updates. On expiry `third` freezes and the FSM goes to SETTLE.
- **SETTLE:** one cycle, allowing the datapath's registered bet and combinational prize to settle. Then go to PAY.
- **PAY:** one cycle with `payout=1`. Load the counter with SHOW_CYCLES and go to SHOW.
- **SHOW:** reels and `bet_out` hold. On expiry go to IDLE. `bet_out` keeps its value in IDLE until the next accepted spin.
- **Ignored inputs while busy:**
  - Spin edges outside IDLE are ignored.
  - A button held through SHOW does not start a new round, because a fresh rising edge is required.
  - `bet` and `balance` changes outside IDLE are ignored.
- **Reset:** reset at any point, including mid-spin or in PAY, aborts the round. The FSM returns to IDLE with no `payout` issued.

## Timing
- **Reset values:**
  - state IDLE, `first`/`second`/`third`=0, `bet_out`=0
  - `payout`=0, `busy`=0, `reject`=0, `spin_d`=0, LFSR=16'hACE1
- **Latency:** with accept at clock edge E0 and S=SPIN_CYCLES, G=STOP_GAP, H=SHOW_CYCLES:
  - SPIN3 occupies E1..ES; reel 1 is final after ES
  - reel 2 is final after E(S+G); reel 3 is final after E(S+2G)
  - `payout` is high for exactly the cycle between E(S+2G+1) and E(S+2G+2)
  - the datapath balance updates at E(S+2G+2)
  - the FSM re-enters IDLE at E(S+2G+2+H)
- **Stability during payout:** `bet_out` and all reels are constant for at least 2 cycles before and during `payout`.
- **Registered outputs:** all outputs are registered; `reject` and `payout` are never high for more than one consecutive cycle.
- **Boundary conditions:**
  - `bet_eff == balance` is accepted.
  - `balance == 0` rejects every request.
  - `bet == 127` locks 100.

## Test plan
Bench parameters: SPIN_CYCLES=4, STOP_GAP=2, SHOW_CYCLES=3.
- **Normal round:** reset, `balance`=100, `bet`=10, spin rising edge at E0 -> `bet_out`=10 from E1; reels move, then freeze in order at E4, E6 and E8; `payout` high only between E9 and E10; `busy` falls at E13.
- **Rejects:** `bet`=0 -> `reject` pulses once, state stays IDLE; `balance`=5, `bet`=6 -> `reject`; `balance`=6, `bet`=6 -> accepted.
- **Clamp:** `bet`=120, `balance`=500 -> `bet_out`=100; changing `bet` to 3 mid-spin leaves `bet_out`=100 through PAY.
- **Held button:** hold `spin` high for 30 cycles -> exactly one round and exactly one `payout`; a release followed by a new edge starts a second round.
- **Reset mid-round:** assert `resetn`=0 in SPIN2 -> the next cycle shows IDLE, reels 0, no `payout` pulse ever appears; the LFSR restarts at ACE1.
- **Deterministic sequence:** from reset, spin at cycle 2 -> final reel values match a reference LFSR model cycle for cycle.
